prog_clk_gen: RTL
=================

// Module: prog_clk_gen
// PURPOSE
//  Synthesisable multi-channel clock/waveform generator. Each of NCH channels produces
//  a divided clock of programmable period and high time (duty cycle) and start phase,
//  derived from the single system clock. Period/duty updates are glitch-free: they are
//  taken only at a period boundary. Drives strobes and derived-rate enables in the design.
// PARAMETERS
//  NCH        4   number of independent output channels
//  CW         16  width of the period, high-time and phase fields (cycles of clk)
//  DEF_PERIOD 10  reset period of every channel (100 MHz clk -> 10 MHz out)
//  DEF_HIGH   4   reset high time of every channel (40 % duty)
// PORTS
//  clk         in   1       system clock; all logic on posedge
//  rst         in   1       synchronous, active-high reset
//  en          in   NCH     per-channel run enable (level)
//  cfg_valid   in   1       config write request
//  cfg_ready   out  1       config can be accepted for channel cfg_ch
//  cfg_ch      in   log2(NCH)  target channel (min width 1)
//  cfg_period  in   CW      new period in clk cycles
//  cfg_high    in   CW      new high time in clk cycles
//  cfg_phase   in   CW      delay (clk cycles) from enable to first period start
//  clk_out     out  NCH     generated waveforms (registered)
//  period_tick out  NCH     1-cycle pulse in the last cycle of each running period
//  running     out  NCH     channel is in DELAY or RUN
// BEHAVIOUR
//  Reset: clk_out=0, period_tick=0, running=0, all channels IDLE, cnt=0,
//   active and shadow cfg = {DEF_PERIOD, DEF_HIGH, phase 0}, pending=0.
//  Per-channel FSM: IDLE -> DELAY -> RUN -> (STOPPING) -> IDLE.
//   IDLE: clk_out=0. en=1 sampled: phase=0 -> RUN with cnt=0; else DELAY with dly=0.
//   DELAY: clk_out=0; dly increments; when dly==phase-1 -> RUN with cnt=0.
//    en=0 in DELAY -> IDLE immediately (no edge was produced).
//   RUN: cnt counts 0..period-1 and wraps to 0. clk_out is a flop loaded from the
//    next-state count, so in every RUN cycle clk_out == (cnt < high).
//    period_tick=1 in the cycle cnt==period-1.
//   en=0 in RUN -> finish current period (no truncated pulse), return to IDLE at wrap.
//    en re-asserted before the wrap cancels the stop; counting is unaffected.
//  Arithmetic rules: period<2 is treated as 2. high==0 -> clk_out constant 0;
//   high>=period -> constant 1. Comparisons unsigned, CW bits, no overflow possible.
//  Config handshake: transfer when cfg_valid && cfg_ready on a clock edge.
//   cfg_ready = ~pending[cfg_ch] (combinational in cfg_ch).
//   A transfer writes the channel shadow and sets pending.
//   IDLE/DELAY channel: shadow copied to active on the next edge; pending clears then.
//    In DELAY the new phase applies from the next enable.
//   RUN channel: shadow copied to active at the wrap (cnt==period-1 -> 0).
//    The new period/high govern from cnt=0. pending clears at that edge.
//   Transfer in the same cycle as the wrap: not applied at that wrap. It applies at the
//    following boundary.
//  Reset mid-operation: all channels return to reset state at that edge. Shadow
//   contents and pending writes are discarded.
//  Latency: en sampled at edge E, phase P -> first clk_out rise after edge E+P
//   (high>0).
// TESTING
//  1 Reset, en[0]=1, defaults -> clk_out[0] high 4 / low 6 cycles repeating;
//    tick every 10th cycle.
//  2 cfg ch1 period=5 high=2 phase=3, en[1]=1 -> 3 low cycles, then 2 high / 3 low.
//  3 Ch0 running, cfg period=8 high=6 mid-period -> current 10-cycle period completes,
//    next is 6H/2L; cfg_ready low until the wrap.
//  4 Deassert en[0] at cnt=2 -> pulse/period completes to cnt=9, then clk_out=0,
//    running=0.
//  5 Corners: high=0 -> constant 0; high=12 with period=10 -> constant 1;
//    period=1 -> behaves as period 2.
//  6 rst pulse mid-RUN with pending cfg -> all outputs 0 next cycle; after re-enable
//    the defaults (10/4) apply.

Source files
------------

// File: rtl/prog_clk_gen_if.sv
// -----------------------------------------------------------------------------
// prog_clk_gen_if
//   Configuration handshake bundle for prog_clk_gen. A config write transfers
//   on a clock edge where cfg_valid && cfg_ready; cfg_ready is combinational
//   in cfg_ch and reflects whether the target channel can take a new shadow.
//
//   Signals
//     cfg_valid   master -> slave  config write request
//     cfg_ready   slave  -> master selected channel can accept a write
//     cfg_ch      master -> slave  target channel index
//     cfg_period  master -> slave  new period in clk cycles
//     cfg_high    master -> slave  new high time in clk cycles
//     cfg_phase   master -> slave  delay from enable to first period start
//
//   Modports
//     master : the configuring agent (driver of the request)
//     slave  : the clock generator (owner of cfg_ready)
// -----------------------------------------------------------------------------
interface prog_clk_gen_if #(
  parameter int NCH = 4,
  parameter int CW  = 16
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_period;
  logic [CW-1:0]  cfg_high;
  logic [CW-1:0]  cfg_phase;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_period,
    output cfg_high,
    output cfg_phase,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_period,
    input  cfg_high,
    input  cfg_phase,
    output cfg_ready
  );
endinterface

// File: rtl/prog_clk_gen.sv
// -----------------------------------------------------------------------------
// prog_clk_gen
//   Multi-channel programmable clock / waveform generator. Each of NCH
//   channels produces a divided clock with programmable period, high time and
//   start phase, all counted in cycles of clk. New settings are written into a
//   per-channel shadow and only become active at a safe point (immediately
//   when the channel is idle or delaying, at the period wrap when running), so
//   the output never carries a truncated or stretched pulse.
//
//   Ports
//     clk            system clock, all logic on posedge
//     rst            synchronous active-high reset
//     en_i           per-channel run enable (level)
//     cfg_if         config handshake (slave modport)
//     clk_out_o      generated waveforms, registered
//     period_tick_o  one-cycle pulse in the last cycle of each running period
//     running_o      channel is delaying, running or finishing its last period
//
//   Per-channel FSM
//     IDLE  -> DELAY (phase > 0) or RUN (phase == 0) when en is sampled high
//     DELAY -> RUN after phase cycles, or back to IDLE if en drops
//     RUN   -> STOP when en drops mid-period; RUN -> IDLE if en is low at wrap
//     STOP  -> RUN if en returns, otherwise IDLE at the wrap
// -----------------------------------------------------------------------------
module prog_clk_gen #(
  parameter int NCH        = 4,
  parameter int CW         = 16,
  parameter int DEF_PERIOD = 10,
  parameter int DEF_HIGH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  en_i,
  prog_clk_gen_if.slave   cfg_if,
  output logic [NCH-1:0]  clk_out_o,
  output logic [NCH-1:0]  period_tick_o,
  output logic [NCH-1:0]  running_o
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;  // RUN with en low: finish the period

  typedef struct packed {
    logic [CW-1:0] period;
    logic [CW-1:0] high;
    logic [CW-1:0] phase;
  } cfg_t;

  localparam cfg_t CFG_RESET = cfg_t'{CW'(DEF_PERIOD), CW'(DEF_HIGH), {CW{1'b0}}};

  // ---------------------------------------------------------------------------
  // Shared handshake logic
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] pend_vec;
  logic           cfg_ready;
  cfg_t           cfg_new;

  assign cfg_new = cfg_t'{cfg_if.cfg_period, cfg_if.cfg_high, cfg_if.cfg_phase};

  // NOTE: every signal written in an always_comb gets a default before any
  // conditional assignment; otherwise an unassigned path infers a latch.
  always_comb begin
    cfg_ready = 1'b0;  // out-of-range channel index is never ready
    for (int c = 0; c < NCH; c++) begin
      if (cfg_if.cfg_ch == CHW'(c)) begin
        cfg_ready = ~pend_vec[c];
      end
    end
  end

  assign cfg_if.cfg_ready = cfg_ready;

  // ---------------------------------------------------------------------------
  // Per-channel generator
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [CW-1:0] dly_q,   dly_d;
    cfg_t          act_q,   act_d;
    cfg_t          shd_q,   shd_d;
    logic          pend_q,  pend_d;
    logic          clk_q,   clk_d;

    logic [CW-1:0] per_eff;
    logic          in_run;
    logic          last;
    logic          apply;
    logic          xfer;

    assign xfer    = cfg_if.cfg_valid && cfg_ready && (cfg_if.cfg_ch == CHW'(g));
    assign in_run  = (state_q == S_RUN) || (state_q == S_STOP);
    // A period below 2 cannot hold both a high and a low cycle; clamp it.
    assign per_eff = (act_q.period < CW'(2)) ? CW'(2) : act_q.period;
    assign last    = (cnt_q == per_eff - CW'(1));
    // Shadow may go live whenever the channel is not mid-period. Using the
    // registered pend_q means a write landing on the wrap edge waits for the
    // following boundary.
    assign apply   = pend_q && (!in_run || last);

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dly_d   = dly_q;
      act_d   = act_q;
      shd_d   = shd_q;
      pend_d  = pend_q;
      clk_d   = 1'b0;

      if (apply) begin
        act_d  = shd_q;
        pend_d = 1'b0;
      end
      // A transfer needs cfg_ready, i.e. pend_q == 0, so it never collides
      // with apply on the same channel.
      if (xfer) begin
        shd_d  = cfg_new;
        pend_d = 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (en_i[g]) begin
            if (act_d.phase == '0) begin
              state_d = S_RUN;
            end else begin
              // The delay counts down from phase-1, so the phase in force at
              // enable time is captured here and later config writes do not
              // disturb a delay already in progress.
              state_d = S_DELAY;
              dly_d   = act_d.phase - CW'(1);
            end
          end
        end

        S_DELAY: begin
          cnt_d = '0;
          if (!en_i[g]) begin
            state_d = S_IDLE;
          end else if (dly_q == '0) begin
            state_d = S_RUN;
          end else begin
            dly_d = dly_q - CW'(1);
          end
        end

        S_RUN: begin
          cnt_d = last ? '0 : cnt_q + CW'(1);
          if (last) begin
            state_d = en_i[g] ? S_RUN : S_IDLE;
          end else if (!en_i[g]) begin
            state_d = S_STOP;
          end
        end

        default: begin  // S_STOP
          cnt_d = last ? '0 : cnt_q + CW'(1);
          if (last) begin
            state_d = en_i[g] ? S_RUN : S_IDLE;
          end else if (en_i[g]) begin
            state_d = S_RUN;
          end
        end
      endcase

      // Output flop is loaded from the next count and the next active config,
      // so in any running cycle clk_out == (cnt < high) with no extra lag.
      // high == 0 gives constant 0, high >= period gives constant 1.
      if ((state_d == S_RUN) || (state_d == S_STOP)) begin
        clk_d = (cnt_d < act_d.high);
      end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        dly_q   <= '0;
        // NOTE: the config registers are reset explicitly (they are small
        // flop banks, not a RAM), which also discards any pending write.
        act_q   <= CFG_RESET;
        shd_q   <= CFG_RESET;
        pend_q  <= 1'b0;
        clk_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        dly_q   <= dly_d;
        act_q   <= act_d;
        shd_q   <= shd_d;
        pend_q  <= pend_d;
        clk_q   <= clk_d;
      end
    end

    assign pend_vec[g]      = pend_q;
    assign clk_out_o[g]     = clk_q;
    assign period_tick_o[g] = in_run && last;
    assign running_o[g]     = (state_q != S_IDLE);
  end

endmodule
